// File: rtl/request_unit_gen_if.sv
// Handshake bundle between the core pipeline, the request unit and the data cache port.
// master drives the pipeline-side inputs; slave is the request unit itself.
interface request_unit_gen_if #(
  parameter int CNT_W = 32
);
  logic             ihit;
  logic             dhit;
  logic             dREN;
  logic             dWEN;
  logic             datomic;
  logic             halt;
  logic             dmemREN;
  logic             dmemWEN;
  logic             dmematomic;
  logic             pending;
  logic             halted;
  logic             timeout;
  logic [CNT_W-1:0] rd_count;
  logic [CNT_W-1:0] wr_count;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output ihit, dhit, dREN, dWEN, datomic, halt,
    input  dmemREN, dmemWEN, dmematomic, pending, halted, timeout,
    input  rd_count, wr_count, stall_count
  );

  modport slave (
    input  ihit, dhit, dREN, dWEN, datomic, halt,
    output dmemREN, dmemWEN, dmematomic, pending, halted, timeout,
    output rd_count, wr_count, stall_count
  );
endinterface

// File: rtl/request_unit_gen.sv
// Data-memory request unit: arms read/write requests on ihit, retires them on dhit,
// with atomic tagging, halt handling, a pending watchdog and saturating counters.
module request_unit_gen #(
  parameter int CNT_W   = 32,
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 200
) (
  input  logic              CLK,
  input  logic              RST,
  request_unit_gen_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_PEND = 2'd1,
    ST_WR_PEND = 2'd2,
    ST_HALTED  = 2'd3
  } state_t;

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

  state_t           state_r;
  state_t           state_n_s;
  logic             pend_s;
  logic             enter_s;
  logic             dmemren_r;
  logic             dmemwen_r;
  logic             atomic_r;
  logic             pending_r;
  logic             halted_r;
  logic             timeout_r;
  logic [TO_W-1:0]  wd_r;
  logic [CNT_W-1:0] rd_count_r;
  logic [CNT_W-1:0] wr_count_r;
  logic [CNT_W-1:0] stall_count_r;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  // Next-state selection; halt beats ihit, write beats read, halt is deferred while pending
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.halt) begin
          state_n_s = ST_HALTED;
        end else if (bus.ihit && bus.dWEN) begin
          state_n_s = ST_WR_PEND;
        end else if (bus.ihit && bus.dREN) begin
          state_n_s = ST_RD_PEND;
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_RD_PEND, ST_WR_PEND: begin
        if (bus.dhit) begin
          state_n_s = ST_IDLE;
        end else begin
          state_n_s = state_r;
        end
      end
      ST_HALTED: state_n_s = ST_HALTED;
      default:   state_n_s = ST_IDLE;
    endcase
  end

  assign pend_s  = (state_r == ST_RD_PEND) || (state_r == ST_WR_PEND);
  assign enter_s = (state_r == ST_IDLE) &&
                   ((state_n_s == ST_RD_PEND) || (state_n_s == ST_WR_PEND));

  // State register and registered request/status outputs decoded from the next state
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= ST_IDLE;
      dmemren_r <= 1'b0;
      dmemwen_r <= 1'b0;
      pending_r <= 1'b0;
      halted_r  <= 1'b0;
      atomic_r  <= 1'b0;
    end else begin
      state_r   <= state_n_s;
      dmemren_r <= (state_n_s == ST_RD_PEND);
      dmemwen_r <= (state_n_s == ST_WR_PEND);
      pending_r <= (state_n_s == ST_RD_PEND) || (state_n_s == ST_WR_PEND);
      halted_r  <= (state_n_s == ST_HALTED);
      if (enter_s) begin
        atomic_r <= bus.datomic;
      end else if (pend_s && bus.dhit) begin
        atomic_r <= 1'b0;
      end
    end
  end

  // Watchdog: restarts per request, stops at the limit; the timeout flag is sticky until reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      wd_r      <= '0;
      timeout_r <= 1'b0;
    end else if (enter_s) begin
      wd_r <= '0;
    end else if (pend_s && !bus.dhit && (wd_r != TO_LIM)) begin
      wd_r <= wd_r + TO_W'(1);
      if (wd_r == (TO_LIM - TO_W'(1))) begin
        timeout_r <= 1'b1;
      end
    end
  end

  // Saturating performance counters; nothing moves outside a pending state
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_count_r    <= '0;
      wr_count_r    <= '0;
      stall_count_r <= '0;
    end else begin
      if ((state_r == ST_RD_PEND) && bus.dhit) begin
        rd_count_r <= sat_inc(rd_count_r);
      end
      if ((state_r == ST_WR_PEND) && bus.dhit) begin
        wr_count_r <= sat_inc(wr_count_r);
      end
      if (pend_s && !bus.dhit) begin
        stall_count_r <= sat_inc(stall_count_r);
      end
    end
  end

  assign bus.dmemREN     = dmemren_r;
  assign bus.dmemWEN     = dmemwen_r;
  assign bus.dmematomic  = atomic_r;
  assign bus.pending     = pending_r;
  assign bus.halted      = halted_r;
  assign bus.timeout     = timeout_r;
  assign bus.rd_count    = rd_count_r;
  assign bus.wr_count    = wr_count_r;
  assign bus.stall_count = stall_count_r;

endmodule

// File: tb/tb_request_unit_gen.sv
// Self-checking bench: two request_unit_gen configurations driven in lockstep and
// compared every cycle against a behavioural model, plus directed scenario checks.
module tb_request_unit_gen;

  localparam int CW_A = 16;
  localparam int TO_A = 7;
  localparam int CW_B = 2;
  localparam int TO_B = 4;

  localparam int M_IDLE = 0;
  localparam int M_RD   = 1;
  localparam int M_WR   = 2;
  localparam int M_HALT = 3;

  logic CLK;
  logic RST;
  logic ihit, dhit, dREN, dWEN, datomic, halt;

  int n_checks;
  int n_fail;

  // Reference model, one slot per instance
  int     m_mode [2];
  bit     m_atom [2];
  int     m_wait [2];
  bit     m_to   [2];
  longint m_rd   [2];
  longint m_wr   [2];
  longint m_st   [2];
  longint cmax   [2];
  int     tlim   [2];

  request_unit_gen_if #(.CNT_W(CW_A)) ifa ();
  request_unit_gen_if #(.CNT_W(CW_B)) ifb ();

  assign ifa.ihit = ihit;  assign ifa.dhit = dhit;  assign ifa.dREN = dREN;
  assign ifa.dWEN = dWEN;  assign ifa.datomic = datomic;  assign ifa.halt = halt;
  assign ifb.ihit = ihit;  assign ifb.dhit = dhit;  assign ifb.dREN = dREN;
  assign ifb.dWEN = dWEN;  assign ifb.datomic = datomic;  assign ifb.halt = halt;

  request_unit_gen #(.CNT_W(CW_A), .TO_W(8), .TIMEOUT(TO_A)) dut_a (
    .CLK(CLK), .RST(RST), .bus(ifa)
  );
  request_unit_gen #(.CNT_W(CW_B), .TO_W(3), .TIMEOUT(TO_B)) dut_b (
    .CLK(CLK), .RST(RST), .bus(ifb)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic longint bump(input longint v, input longint mx);
    return (v < mx) ? v + 1 : v;
  endfunction

  task automatic model_edge(input int i);
    if (RST) begin
      m_mode[i] = M_IDLE; m_atom[i] = 1'b0; m_wait[i] = 0; m_to[i] = 1'b0;
      m_rd[i] = 0; m_wr[i] = 0; m_st[i] = 0;
    end else if (m_mode[i] == M_IDLE) begin
      if (halt) m_mode[i] = M_HALT;
      else if (ihit && (dWEN || dREN)) begin
        m_mode[i] = dWEN ? M_WR : M_RD;
        m_atom[i] = datomic;
        m_wait[i] = 0;
      end
    end else if (m_mode[i] != M_HALT) begin
      if (dhit) begin
        if (m_mode[i] == M_RD) m_rd[i] = bump(m_rd[i], cmax[i]);
        else m_wr[i] = bump(m_wr[i], cmax[i]);
        m_mode[i] = M_IDLE;
        m_atom[i] = 1'b0;
      end else begin
        m_st[i] = bump(m_st[i], cmax[i]);
        m_wait[i]++;
        if (m_wait[i] >= tlim[i]) m_to[i] = 1'b1;
      end
    end
  endtask

  task automatic compare(input int i, input logic ren, input logic wen, input logic atm,
                         input logic pnd, input logic hlt, input logic tmo,
                         input logic [63:0] rc, input logic [63:0] wc, input logic [63:0] sc);
    string s;
    s = (i == 0) ? "a" : "b";
    check({"dmemREN_", s}, ren, (m_mode[i] == M_RD));
    check({"dmemWEN_", s}, wen, (m_mode[i] == M_WR));
    check({"dmematomic_", s}, atm, m_atom[i]);
    check({"pending_", s}, pnd, (m_mode[i] == M_RD) || (m_mode[i] == M_WR));
    check({"halted_", s}, hlt, (m_mode[i] == M_HALT));
    check({"timeout_", s}, tmo, m_to[i]);
    check({"rd_count_", s}, rc, m_rd[i]);
    check({"wr_count_", s}, wc, m_wr[i]);
    check({"stall_count_", s}, sc, m_st[i]);
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge(0);
    model_edge(1);
    #1;
    compare(0, ifa.dmemREN, ifa.dmemWEN, ifa.dmematomic, ifa.pending, ifa.halted,
            ifa.timeout, 64'(ifa.rd_count), 64'(ifa.wr_count), 64'(ifa.stall_count));
    compare(1, ifb.dmemREN, ifb.dmemWEN, ifb.dmematomic, ifb.pending, ifb.halted,
            ifb.timeout, 64'(ifb.rd_count), 64'(ifb.wr_count), 64'(ifb.stall_count));
  endtask

  task automatic idle_inputs();
    ihit = 1'b0; dhit = 1'b0; dREN = 1'b0; dWEN = 1'b0; datomic = 1'b0; halt = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
  endtask

  initial begin
    int pct;
    n_checks = 0;
    n_fail   = 0;
    cmax = '{65535, 3};
    tlim = '{TO_A, TO_B};
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = M_HALT; m_atom[i] = 1'b0; m_wait[i] = 0; m_to[i] = 1'b0;
      m_rd[i] = 0; m_wr[i] = 0; m_st[i] = 0;
    end
    RST = 1'b0;
    idle_inputs();
    #2;
    do_reset();

    // Atomic read, dhit on the third pending edge
    ihit = 1'b1; dREN = 1'b1; datomic = 1'b1;
    step();
    check("rd_armed_atomic", {ifa.dmemREN, ifa.dmematomic}, 2'b11);
    idle_inputs();
    step();
    step();
    dhit = 1'b1;
    step();
    dhit = 1'b0;
    check("rd_retired_ren", ifa.dmemREN, 1'b0);
    check("rd_count_one", 64'(ifa.rd_count), 64'd1);
    check("stall_two", 64'(ifa.stall_count), 64'd2);

    // Simultaneous read and write request -> write only
    ihit = 1'b1; dREN = 1'b1; dWEN = 1'b1;
    step();
    idle_inputs();
    check("wr_priority", {ifa.dmemWEN, ifa.dmemREN}, 2'b10);
    dhit = 1'b1;
    step();
    dhit = 1'b0;
    check("wr_count_one", 64'(ifa.wr_count), 64'd1);
    check("rd_count_kept", 64'(ifa.rd_count), 64'd1);

    // Watchdog on instance b (limit 4): withhold dhit for 10 cycles
    ihit = 1'b1; dREN = 1'b1;
    step();
    idle_inputs();
    for (int k = 0; k < 10; k++) step();
    check("timeout_set", {ifb.timeout, ifb.dmemREN}, 2'b11);
    dhit = 1'b1;
    step();
    dhit = 1'b0;
    step();
    check("timeout_sticky", {ifb.timeout, ifb.dmemREN}, 2'b10);

    // Halt during a read is deferred until the read retires
    do_reset();
    ihit = 1'b1; dREN = 1'b1;
    step();
    ihit = 1'b0; dREN = 1'b0; halt = 1'b1;
    step();
    step();
    dhit = 1'b1;
    step();
    dhit = 1'b0;
    check("halt_deferred", {ifa.halted, 64'(ifa.rd_count)}, {1'b0, 64'd1});
    step();
    check("halted_entered", ifa.halted, 1'b1);
    halt = 1'b0; ihit = 1'b1; dREN = 1'b1; dhit = 1'b1;
    for (int k = 0; k < 4; k++) step();
    check("halted_no_req", {ifa.dmemREN, ifa.halted}, 2'b01);

    // Five writes: instance b saturates at 3
    do_reset();
    for (int k = 0; k < 5; k++) begin
      ihit = 1'b1; dWEN = 1'b1;
      step();
      idle_inputs();
      dhit = 1'b1;
      step();
      dhit = 1'b0;
    end
    check("wr_sat_b", 64'(ifb.wr_count), 64'd3);
    check("wr_nosat_a", 64'(ifa.wr_count), 64'd5);

    // Randomised traffic with varying dhit density
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      case ((c / 500) % 3)
        0:       pct = 50;
        1:       pct = 15;
        default: pct = 4;
      endcase
      RST     = ($urandom_range(0, 249) == 0);
      halt    = ($urandom_range(0, 199) == 0);
      ihit    = ($urandom_range(0, 1) == 1);
      dREN    = ($urandom_range(0, 1) == 1);
      dWEN    = ($urandom_range(0, 2) == 0);
      datomic = ($urandom_range(0, 1) == 1);
      dhit    = ($urandom_range(0, 99) < pct);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
